// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and board-level timing defaults for the CPU run controller
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BRK = 2'd3} run_state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_RUN_DIV = 5000000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus counting debouncer with a one-cycle rising-edge pulse
module btn_debounce import cpu_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W = 24
) (
    input  logic sysclk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);
    logic [1:0] sync, vld;
    logic [CNT_W-1:0] cnt;
    logic armed, flip;
    assign flip = sync[1] != level && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    // rise is armed only once a genuine low has been seen, so an input held high through reset never fires it
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            vld   <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            vld   <= {vld[0], 1'b1};
            cnt   <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
            level <= level ^ flip;
            rise  <= flip && !level && armed;
            armed <= armed || (vld[1] && !sync[1] && !level);
        end
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller producing a one-cycle CPU clock enable
module cpu_run_ctrl import cpu_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV = DEF_RUN_DIV,
    parameter int CNT_W = 24
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        bp_en,
    input  logic [7:0]  bp_pc,
    input  logic [7:0]  cpu_pc,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [15:0] cycle_cnt
);
    logic step_lvl, step_rise, step_p, run_lvl, run_rise, tc, hit;
    logic [CNT_W-1:0] div;
    run_state_t st, nxt;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step (
        .sysclk(sysclk), .reset(reset), .din(btn_step), .level(step_lvl), .rise(step_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_run (
        .sysclk(sysclk), .reset(reset), .din(sw_run), .level(run_lvl), .rise(run_rise)
    );
    assign step_p = step_rise && step_lvl;
    assign tc     = div == CNT_W'(RUN_DIV - 1);
    assign hit    = bp_en && cpu_pc == bp_pc;
    assign state  = st;
    always_comb begin
        nxt = st;
        case (st)
            HALT:    nxt = run_rise ? RUN : step_p ? STEP : HALT;
            RUN:     nxt = !run_lvl ? HALT : (tc && hit) ? BRK : RUN;
            STEP:    nxt = HALT;
            BRK:     nxt = !run_lvl ? HALT : step_p ? STEP : BRK;
            default: nxt = HALT;
        endcase
    end
    // cpu_en is decoded from the next state so it lines up with STEP and the wrapped divider
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            st        <= HALT;
            cpu_en    <= 1'b0;
            div       <= '0;
            cycle_cnt <= '0;
        end else begin
            st     <= nxt;
            cpu_en <= nxt == STEP || (st == RUN && nxt == RUN && tc);
            div    <= (st != RUN || tc) ? '0 : div + 1'b1;
            if (cpu_en && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed and randomized checks of cpu_run_ctrl against pulse-timing arithmetic
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;
    localparam int DB = 4;
    localparam int DIV = 8;
    localparam int STEP_LAT = DB + 3;
    localparam int RUN_LAT = DB + 3 + DIV;
    logic sysclk = 1'b0, reset = 1'b0, btn_step = 1'b0, sw_run = 1'b0, bp_en = 1'b0;
    logic [7:0] bp_pc = 8'h00, cpu_pc = 8'h00;
    logic cpu_en;
    logic [1:0] state;
    logic [15:0] cycle_cnt;
    int checks = 0, errors = 0, cyc = 0, exp_cnt = 0;
    int t0, t1, k, n;
    int pulses[$];
    logic pc_follow = 1'b0;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(24)) dut (
        .sysclk(sysclk), .reset(reset), .btn_step(btn_step), .sw_run(sw_run),
        .bp_en(bp_en), .bp_pc(bp_pc), .cpu_pc(cpu_pc),
        .cpu_en(cpu_en), .state(state), .cycle_cnt(cycle_cnt)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        cyc++;
        if (cpu_en === 1'b1) begin
            pulses.push_back(cyc);
            if (pc_follow) cpu_pc++;
        end
    endtask

    task automatic ticks(input int cnt);
        repeat (cnt) tick();
    endtask

    function automatic int pulse_at(input int i);
        return i < pulses.size() ? pulses[i] : -1;
    endfunction

    task automatic press(input int hold, output int start);
        int nb;
        nb = int'($urandom_range(0, 2));
        for (int i = 0; i < nb; i++) begin
            btn_step = 1'b1;
            ticks(int'($urandom_range(1, DB - 1)));
            btn_step = 1'b0;
            ticks(int'($urandom_range(1, 3)));
        end
        btn_step = 1'b1;
        start = cyc;
        ticks(hold);
        btn_step = 1'b0;
        ticks(12);
    endtask

    task automatic model_pulse();
        exp_cnt = exp_cnt < 65535 ? exp_cnt + 1 : 65535;
    endtask

    initial begin
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            btn_step = 1'($urandom_range(0, 1));
            sw_run = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_state", int'(state), int'(HALT));
        check("rst_en", int'(cpu_en), 0);
        check("rst_cnt", int'(cycle_cnt), 0);
        check("rst_pulses", pulses.size(), 0);
        btn_step = 1'b0;
        sw_run = 1'b0;
        tick();
        reset = 1'b0;
        ticks(5);

        btn_step = 1'b1; tick();
        btn_step = 1'b0; tick();
        btn_step = 1'b1; tick();
        btn_step = 1'b0; tick();
        btn_step = 1'b1;
        t0 = cyc;
        ticks(STEP_LAT);
        check("bounce_step_state", int'(state), int'(STEP));
        check("bounce_step_en", int'(cpu_en), 1);
        tick();
        check("bounce_after_state", int'(state), int'(HALT));
        ticks(10 - STEP_LAT - 1);
        btn_step = 1'b0;
        ticks(12);
        model_pulse();
        check("bounce_npulse", pulses.size(), 1);
        check("bounce_time", pulse_at(0), t0 + STEP_LAT);
        check("bounce_cnt", int'(cycle_cnt), exp_cnt);
        pulses.delete();

        n = int'($urandom_range(2, 4));
        for (int i = 0; i < n; i++) begin
            press(int'($urandom_range(6, 12)), t0);
            model_pulse();
            check("rand_step_npulse", pulses.size(), 1);
            check("rand_step_time", pulse_at(0), t0 + STEP_LAT);
            pulses.delete();
        end
        check("rand_step_cnt", int'(cycle_cnt), exp_cnt);

        sw_run = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 80 && pulses.size() < 5; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("run_pulse_time", pulse_at(i), t0 + RUN_LAT + i * DIV);
            model_pulse();
        end
        check("run_state", int'(state), int'(RUN));
        tick();
        sw_run = 1'b0;
        ticks(20);
        check("run_stop_npulse", pulses.size(), 5);
        check("run_stop_state", int'(state), int'(HALT));
        check("run_cnt", int'(cycle_cnt), exp_cnt);
        pulses.delete();

        k = int'($urandom_range(1, 4));
        bp_en = 1'b1;
        bp_pc = 8'h10;
        cpu_pc = 8'(16 - k);
        pc_follow = 1'b1;
        sw_run = 1'b1;
        t0 = cyc;
        ticks(RUN_LAT + k * DIV);
        check("brk_state", int'(state), int'(BRK));
        check("brk_en", int'(cpu_en), 0);
        check("brk_npulse", pulses.size(), k);
        check("brk_last", pulse_at(k - 1), t0 + RUN_LAT + (k - 1) * DIV);
        check("brk_pc", int'(cpu_pc), 16);
        pc_follow = 1'b0;
        ticks(20);
        check("brk_hold_state", int'(state), int'(BRK));
        check("brk_hold_npulse", pulses.size(), k);
        for (int i = 0; i < k; i++) model_pulse();
        press(10, t1);
        model_pulse();
        check("brk_step_npulse", pulses.size(), k + 1);
        check("brk_step_time", pulse_at(k), t1 + STEP_LAT);
        check("brk_step_state", int'(state), int'(HALT));
        ticks(20);
        check("brk_no_rerun", pulses.size(), k + 1);
        sw_run = 1'b0;
        bp_en = 1'b0;
        ticks(12);
        check("brk_cnt", int'(cycle_cnt), exp_cnt);
        pulses.delete();

        force dut.cycle_cnt = 16'hFFFD;
        tick();
        release dut.cycle_cnt;
        tick();
        exp_cnt = 65533;
        check("sat_preload", int'(cycle_cnt), exp_cnt);
        for (int i = 0; i < 3; i++) begin
            press(int'($urandom_range(6, 12)), t0);
            model_pulse();
            check("sat_cnt", int'(cycle_cnt), exp_cnt);
        end
        pulses.delete();

        sw_run = 1'b1;
        t0 = cyc;
        ticks(RUN_LAT + DIV - 1);
        check("rstrun_npulse", pulses.size(), 1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btn_step = ~btn_step;
            tick();
        end
        check("rstrun_state", int'(state), int'(HALT));
        check("rstrun_en", int'(cpu_en), 0);
        check("rstrun_cnt", int'(cycle_cnt), 0);
        check("rstrun_npulse2", pulses.size(), 1);
        btn_step = 1'b0;
        reset = 1'b0;
        ticks(30);
        check("rstrun_held_state", int'(state), int'(HALT));
        check("rstrun_held_npulse", pulses.size(), 1);
        sw_run = 1'b0;
        ticks(12);
        sw_run = 1'b1;
        t1 = cyc;
        ticks(RUN_LAT + 1);
        check("rerun_state", int'(state), int'(RUN));
        check("rerun_npulse", pulses.size(), 2);
        check("rerun_time", pulse_at(1), t1 + RUN_LAT);
        sw_run = 1'b0;
        ticks(12);
        check("rerun_cnt", int'(cycle_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
